// File: rtl/pattern_detector_multi_if.sv
// Bundle of the serial-stream, pattern-load and match-report signals of the
// multi-pattern detector. The source side (master) drives the stream and the
// slot writes. The detector (slave) returns the match pulses and the count.
interface pattern_detector_multi_if #(
    parameter int PAT_W   = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
);
    logic               data_in;
    logic               input_valid;
    logic               load_pattern;
    logic [IDX_W-1:0]   load_idx;
    logic [PAT_W-1:0]   pattern;
    logic [PAT_W-1:0]   mask;
    logic               overlap_en;
    logic               clear_count;
    logic               match;
    logic [NUM_PAT-1:0] match_vec;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output data_in, input_valid, load_pattern, load_idx, pattern, mask,
               overlap_en, clear_count,
        input  match, match_vec, match_count
    );

    modport slave (
        input  data_in, input_valid, load_pattern, load_idx, pattern, mask,
               overlap_en, clear_count,
        output match, match_vec, match_count
    );
endinterface

// File: rtl/pattern_detector_multi.sv
// Multi-slot serial pattern detector. An MSB-first bit stream is shifted into
// a PAT_W-bit window and compared against NUM_PAT loadable pattern/mask slots.
// Hits are registered as one-cycle pulses and counted in a saturating counter.
module pattern_detector_multi #(
    parameter int PAT_W   = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    pattern_detector_multi_if.slave     bus
);
    localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]   shreg_reg;
    logic [PAT_W-1:0]   shreg_next;
    logic [FILL_W-1:0]  fill_reg;
    logic [FILL_W-1:0]  fill_next;
    logic               full_next;
    logic [NUM_PAT-1:0] hit_vec;
    logic               any_hit;
    logic [NUM_PAT-1:0] match_vec_reg;
    logic               match_reg;
    logic [CNT_W-1:0]   count_reg;

    // Post-shift window and fill level; compares look at the bit being sampled now.
    always_comb begin
        shreg_next = shreg_reg;
        fill_next  = fill_reg;
        if (bus.input_valid) begin
            shreg_next = {shreg_reg[PAT_W-2:0], bus.data_in};
            fill_next  = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
        end
    end

    assign full_next = (fill_next == FILL_FULL);
    assign any_hit   = |hit_vec;

    // One storage/compare lane per slot. A load lands at the edge, so a bit
    // sampled on the same edge still compares against the old contents.
    // Indices beyond NUM_PAT match no lane and are therefore ignored.
    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_slot
        logic [PAT_W-1:0] pat_reg;
        logic [PAT_W-1:0] msk_reg;
        logic             valid_reg;

        // Slot write on load_pattern addressed to this lane.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pat_reg   <= '0;
                msk_reg   <= '0;
                valid_reg <= 1'b0;
            end else if (bus.load_pattern && (bus.load_idx == IDX_W'(gi))) begin
                pat_reg   <= bus.pattern;
                msk_reg   <= bus.mask;
                valid_reg <= 1'b1;
            end
        end

        assign hit_vec[gi] = bus.input_valid & valid_reg & full_next &
                             ~|((shreg_next ^ pat_reg) & msk_reg);
    end

    // Window and fill update. In non-overlapping mode a hit empties the fill
    // so the next report needs a full set of fresh bits; shreg keeps its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_reg <= '0;
            fill_reg  <= '0;
        end else if (bus.input_valid) begin
            shreg_reg <= shreg_next;
            fill_reg  <= (any_hit && !bus.overlap_en) ? '0 : fill_next;
        end
    end

    // Registered match pulses and saturating hit counter (clear wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_vec_reg <= '0;
            match_reg     <= 1'b0;
            count_reg     <= '0;
        end else begin
            match_vec_reg <= hit_vec;
            match_reg     <= any_hit;
            if (bus.clear_count) begin
                count_reg <= '0;
            end else if (any_hit && (count_reg != CNT_MAX)) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.match       = match_reg;
    assign bus.match_vec   = match_vec_reg;
    assign bus.match_count = count_reg;
endmodule

// File: tb/tb_pattern_detector_multi.sv
// Directed bench for pattern_detector_multi at PAT_W=4, NUM_PAT=2, CNT_W=2.
module tb_pattern_detector_multi;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pattern_detector_multi_if #(.PAT_W(4), .NUM_PAT(2), .CNT_W(2)) bus ();

    pattern_detector_multi #(.PAT_W(4), .NUM_PAT(2), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given inputs; returns 1 time unit after the edge.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic [0:0] idx, input logic [3:0] p,
                         input logic [3:0] m, input logic clr);
        bus.input_valid  = v;
        bus.data_in      = b;
        bus.load_pattern = ld;
        bus.load_idx     = idx;
        bus.pattern      = p;
        bus.mask         = m;
        bus.clear_count  = clr;
        @(posedge clk);
        #1;
        bus.input_valid  = 1'b0;
        bus.load_pattern = 1'b0;
        bus.clear_count  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (bus.match !== 1'b0 || bus.match_vec !== 2'b00 || bus.match_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_assert: match=%b vec=%b cnt=%0d required 0/00/0",
                     bus.match, bus.match_vec, bus.match_count);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        total++;
        if (bus.match !== 1'b0 || bus.match_vec !== 2'b00 || bus.match_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: match=%b vec=%b cnt=%0d required 0/00/0",
                     bus.match, bus.match_vec, bus.match_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_overlap;
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp0 = 6'b000101;
        do_reset();
        bus.overlap_en = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bits[5-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== {1'b0, exp0[5-i]} || bus.match !== exp0[5-i]) begin
                bad++;
                $display("FAIL overlap bit%0d: vec=%b match=%b required vec=%b",
                         i + 1, bus.match_vec, bus.match, {1'b0, exp0[5-i]});
            end
        end
        total++;
        if (bus.match_count !== 2'd2) begin
            bad++;
            $display("FAIL overlap_count: got %0d required 2", bus.match_count);
        end
        $display("test_overlap done");
    endtask

    task automatic test_non_overlap;
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp0 = 6'b000100;
        do_reset();
        bus.overlap_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bits[5-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== {1'b0, exp0[5-i]}) begin
                bad++;
                $display("FAIL non_overlap bit%0d: vec=%b required %b",
                         i + 1, bus.match_vec, {1'b0, exp0[5-i]});
            end
        end
        total++;
        if (bus.match_count !== 2'd1) begin
            bad++;
            $display("FAIL non_overlap_count: got %0d required 1", bus.match_count);
        end
        bus.overlap_en = 1'b1;
        $display("test_non_overlap done");
    endtask

    task automatic test_multi_slot_saturate;
        logic [15:0] bits = 16'b1110_1000_1010_1010;
        logic [15:0] clrs = 16'b0000_0000_0000_0100;
        logic [1:0]  ev [16] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10,
                                 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
        logic [1:0]  ec [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        do_reset();
        bus.overlap_en = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b1001, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, bits[15-i], 1'b0, 1'b0, 4'h0, 4'h0, clrs[15-i]);
            total++;
            if (bus.match_vec !== ev[i] || bus.match_count !== ec[i]) begin
                bad++;
                $display("FAIL multi_slot bit%0d: vec=%b cnt=%0d required vec=%b cnt=%0d",
                         i + 1, bus.match_vec, bus.match_count, ev[i], ec[i]);
            end
        end
        $display("test_multi_slot_saturate done");
    endtask

    task automatic test_idle_hold;
        logic [2:0] bits = 3'b110;
        logic [2:0] exp0 = 3'b001;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1110, 4'b1111, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== 2'b00) begin
                bad++;
                $display("FAIL idle cycle%0d: vec=%b required 00", i, bus.match_vec);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bits[2-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== {1'b0, exp0[2-i]}) begin
                bad++;
                $display("FAIL idle_resume bit%0d: vec=%b required %b",
                         i + 2, bus.match_vec, {1'b0, exp0[2-i]});
            end
        end
        $display("test_idle_hold done");
    endtask

    task automatic test_midstream_load;
        logic [5:0] bits = 6'b110000;
        logic [5:0] exp0 = 6'b000101;
        // Separate load cycle between bits 2 and 3.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1111, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        total++;
        if (bus.match_vec !== 2'b00) begin
            bad++;
            $display("FAIL midload_bit3: vec=%b required 00", bus.match_vec);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        total++;
        if (bus.match_vec !== 2'b01) begin
            bad++;
            $display("FAIL midload_bit4: vec=%b required 01", bus.match_vec);
        end
        // Load coincident with bit 3.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1111, 1'b0);
        total++;
        if (bus.match_vec !== 2'b00) begin
            bad++;
            $display("FAIL coload_bit3: vec=%b required 00", bus.match_vec);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        total++;
        if (bus.match_vec !== 2'b01) begin
            bad++;
            $display("FAIL coload_bit4: vec=%b required 01", bus.match_vec);
        end
        // Full window: bit 4 of this run matches the old 1100 while 0000 is
        // being loaded; 0000 only takes effect on later bits.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bits[5-i], (i == 3), 1'b0, 4'b0000, 4'b1111, 1'b0);
            total++;
            if (bus.match_vec !== {1'b0, exp0[5-i]}) begin
                bad++;
                $display("FAIL coload_run bit%0d: vec=%b required %b",
                         i + 1, bus.match_vec, {1'b0, exp0[5-i]});
            end
        end
        total++;
        if (bus.match_count !== 2'd3) begin
            bad++;
            $display("FAIL coload_count: got %0d required 3", bus.match_count);
        end
        $display("test_midstream_load done");
    endtask

    task automatic test_dont_care;
        logic [4:0] bits = 5'b01001;
        logic [4:0] exp1 = 5'b00011;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bits[4-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== {exp1[4-i], 1'b0}) begin
                bad++;
                $display("FAIL dont_care bit%0d: vec=%b required %b",
                         i + 1, bus.match_vec, {exp1[4-i], 1'b0});
            end
        end
        $display("test_dont_care done");
    endtask

    task automatic test_async_reset;
        logic [5:0] pre  = 6'b101010;
        logic [4:0] post = 5'b01010;
        logic [4:0] exp0 = 5'b00001;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, pre[5-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        total++;
        if (bus.match !== 1'b1 || bus.match_count !== 2'd2) begin
            bad++;
            $display("FAIL async_pre: match=%b cnt=%0d required 1/2", bus.match, bus.match_count);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.match !== 1'b0 || bus.match_vec !== 2'b00 || bus.match_count !== 2'd0) begin
            bad++;
            $display("FAIL async_assert: match=%b vec=%b cnt=%0d required 0/00/0",
                     bus.match, bus.match_vec, bus.match_count);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, post[4-i], 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.match_vec !== {1'b0, exp0[4-i]}) begin
                bad++;
                $display("FAIL async_resume bit%0d: vec=%b required %b",
                         i + 1, bus.match_vec, {1'b0, exp0[4-i]});
            end
        end
        total++;
        if (bus.match_count !== 2'd1) begin
            bad++;
            $display("FAIL async_count: got %0d required 1", bus.match_count);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b0;
        bus.data_in      = 1'b0;
        bus.input_valid  = 1'b0;
        bus.load_pattern = 1'b0;
        bus.load_idx     = 1'b0;
        bus.pattern      = 4'h0;
        bus.mask         = 4'h0;
        bus.overlap_en   = 1'b1;
        bus.clear_count  = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_multi_slot_saturate();
        test_idle_hold();
        test_midstream_load();
        test_dont_care();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
